// File: rtl/pe_acc_pkg.sv
// Shared types and default widths for the partial-sum accumulator/drain block.
package pe_acc_pkg;

  localparam int DEFAULT_ACC_BW = 32;
  localparam int DEFAULT_CNT_BW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/pe_acc_add.sv
// Accumulator adder with carry-out detection.
// Build option: PE_ACC_SAT_EN clamps an overflowing sum to all ones instead of wrapping.
module pe_acc_add #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b};
  assign ovf  = full[W];

`ifdef PE_ACC_SAT_EN
  // Once clamped, any nonzero addend overflows again, so the run stays at all ones.
  assign sum = full[W] ? {W{1'b1}} : full[W-1:0];
`else
  assign sum = full[W-1:0];
`endif

endmodule

// File: rtl/pe_acc_drain.sv
// Accumulates acc_len partial sums per run and holds the result until drained.
// Build option: PE_ACC_SAT_EN (saturating accumulation, handled in pe_acc_add).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; valid never depends on ready, and out_data/out_ovf are stable while
// out_valid is high and out_ready is low.
module pe_acc_drain
  import pe_acc_pkg::*;
#(
  parameter int ACC_BW = DEFAULT_ACC_BW,
  parameter int CNT_BW = DEFAULT_CNT_BW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ACC_BW-1:0] in_data,
  output logic              in_ready,
  input  logic [CNT_BW-1:0] acc_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_BW-1:0] out_data,
  output logic              out_ovf,
  output state_t            dbg_state
);

  state_t            state_q, state_d;
  logic [ACC_BW-1:0] acc_q, acc_d;
  logic [CNT_BW-1:0] cnt_q, cnt_d;
  logic [CNT_BW-1:0] len_q, len_d;
  logic              ovf_q, ovf_d;

  logic              accept;
  logic [CNT_BW-1:0] len_first;
  logic [CNT_BW-1:0] cnt_inc;
  logic [ACC_BW-1:0] add_sum;
  logic              add_ovf;

  pe_acc_add #(.W(ACC_BW)) u_add (
    .a   (acc_q),
    .b   (in_data),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  assign accept    = in_valid && in_ready;
  // A zero length is treated as a single-beat run.
  assign len_first = (acc_len == '0) ? CNT_BW'(1) : acc_len;
  assign cnt_inc   = cnt_q + CNT_BW'(1);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = in_data;
          len_d   = len_first;
          cnt_d   = CNT_BW'(1);
          ovf_d   = 1'b0;
          state_d = (len_first == CNT_BW'(1)) ? HOLD : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          acc_d = add_sum;
          ovf_d = ovf_q | add_ovf;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = HOLD;
        end
      end
      HOLD: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pe_acc_drain.sv
// Self-checking bench for pe_acc_drain: directed cases plus randomized traffic
// scored against a run-level sum model.
module tb_pe_acc_drain;
  import pe_acc_pkg::*;

  localparam int W      = 32;
  localparam int CNT_BW = 8;
  localparam logic [W-1:0] ALL1 = '1;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [W-1:0]      in_data;
  logic              in_ready;
  logic [CNT_BW-1:0] acc_len;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic              out_ovf;
  state_t            dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  pe_acc_drain #(.ACC_BW(W), .CNT_BW(CNT_BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .acc_len   (acc_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    n_cmp++;
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: tracks the exact sum of each run, result derived at the end
  logic [W:0]  exp_q[$];
  logic [63:0] m_sum;
  int          m_cnt = 0;
  int          m_len = 0;
  bit          m_pending = 0;
  bit          m_live = 0;

  function automatic logic [W:0] run_result(input logic [63:0] s);
    logic          o;
    logic [W-1:0]  d;
    o = (s >= (64'd1 << W));
`ifdef PE_ACC_SAT_EN
    d = o ? ALL1 : s[W-1:0];
`else
    d = s[W-1:0];
`endif
    return {o, d};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_live    = 1;
      m_pending = 0;
      m_cnt     = 0;
      exp_q.delete();
    end else if (m_live) begin
      if (m_pending) begin
        if (out_ready) begin
          m_pending = 0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end else if (in_valid) begin
        if (m_cnt == 0) begin
          m_len = (acc_len == 0) ? 1 : int'(acc_len);
          m_sum = 64'(in_data);
        end else begin
          m_sum = m_sum + 64'(in_data);
        end
        m_cnt++;
        if (m_cnt == m_len) begin
          exp_q.push_back(run_result(m_sum));
          m_pending = 1;
          m_cnt     = 0;
        end
      end
    end
  end

  // record every result the DUT actually hands over (pre-edge values)
  logic [W-1:0] last_data;
  logic         last_ovf;
  int           n_out = 0;

  always @(posedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      last_data = out_data;
      last_ovf  = out_ovf;
      n_out++;
    end
  end

  // scoreboard compare, every cycle, on the falling edge
  always @(negedge clk) begin
    if (m_live) begin
      check("in_ready", 64'(in_ready), 64'(!m_pending));
      check("out_valid", 64'(out_valid), 64'(m_pending));
      if (m_pending) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL exp_q_empty: got pending result expected queued entry at %0t", $time);
        end else begin
          check("out_data", 64'(out_data), 64'(exp_q[0][W-1:0]));
          check("out_ovf", 64'(out_ovf), 64'(exp_q[0][W]));
        end
      end
    end
  end

  // driver tasks (called just after a falling edge)
  task automatic send(input logic [W-1:0] d, input int len);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    acc_len  = CNT_BW'(len);
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 20 cycles");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int n_before;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    acc_len   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_state", 64'(dbg_state), 64'(IDLE));

    // A: four beats, immediate drain, one-cycle valid pulse
    out_ready = 1'b1;
    send(32'd1, 4);
    send(32'd2, 4);
    send(32'd3, 4);
    check("A_valid_pre", 64'(out_valid), 64'd0);
    send(32'd4, 4);
    check("A_valid", 64'(out_valid), 64'd1);
    check("A_data", 64'(out_data), 64'd10);
    check("A_ovf", 64'(out_ovf), 64'd0);
    @(negedge clk);
    check("A_valid_drop", 64'(out_valid), 64'd0);
    check("A_last", 64'(last_data), 64'd10);

    // B: zero length behaves as one beat
    send(32'h55, 0);
    check("B_valid", 64'(out_valid), 64'd1);
    check("B_data", 64'(out_data), 64'h55);
    @(negedge clk);

    // C: back-pressure in HOLD
    out_ready = 1'b0;
    send(32'd7, 3);
    send(32'd8, 3);
    send(32'd9, 3);
    for (int i = 0; i < 5; i++) begin
      check("C_in_ready", 64'(in_ready), 64'd0);
      check("C_data", 64'(out_data), 64'd24);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("C_state", 64'(dbg_state), 64'(IDLE));
    check("C_in_ready_back", 64'(in_ready), 64'd1);
    check("C_last", 64'(last_data), 64'd24);

    // D: overflow
    send(32'hFFFF_FFFF, 2);
    send(32'h2, 2);
    check("D_ovf", 64'(out_ovf), 64'd1);
`ifdef PE_ACC_SAT_EN
    check("D_data", 64'(out_data), 64'hFFFF_FFFF);
`else
    check("D_data", 64'(out_data), 64'h1);
`endif
    @(negedge clk);

    // E: reset mid-run discards, then fresh run
    n_before = n_out;
    send(32'd1, 4);
    send(32'd2, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("E_no_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    check("E_no_out", 64'(n_out), 64'(n_before));
    send(32'd5, 2);
    send(32'd6, 2);
    check("E_data", 64'(out_data), 64'd11);
    @(negedge clk);

    // F: acc_len change mid-run ignored
    send(32'd10, 4);
    send(32'd20, 1);
    check("F_no_early", 64'(out_valid), 64'd0);
    send(32'd30, 1);
    check("F_no_early2", 64'(out_valid), 64'd0);
    send(32'd40, 1);
    check("F_valid", 64'(out_valid), 64'd1);
    check("F_data", 64'(out_data), 64'd100);
    @(negedge clk);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      int sel;
      rst       = ($urandom_range(0, 199) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      acc_len   = CNT_BW'($urandom_range(0, 5));
      sel = $urandom_range(0, 3);
      if (sel == 0) in_data = $urandom_range(32'hFFFF_FF00, 32'hFFFF_FFFF);
      else if (sel == 1) in_data = $urandom;
      else in_data = $urandom_range(0, 1000);
      @(negedge clk);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
